// File: rtl/rng_fetch_ctrl.sv
// rng_fetch_ctrl: drives a 128-bit LFSR generator (warm-up, stir, latch) and serves each
// captured word as OUT_W-bit chunks over valid/ready. Optional repetition test: `RNG_HEALTH_EN.
module rng_fetch_ctrl #(
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter int unsigned STIR_CYCLES   = 16,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned REP_LIMIT     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [127:0]     rng_in,
    output logic             gen_enable,
    output logic             gen_latch,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             health_fail
);
    localparam int unsigned NCHUNK  = 128 / OUT_W;
    localparam int unsigned IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CNT_MAX = (WARMUP_CYCLES > STIR_CYCLES) ? WARMUP_CYCLES : STIR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_STIR    = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_SERVE   = 3'd5;
    localparam logic [2:0] S_FAIL    = 3'd6;

    if ((128 % OUT_W) != 0) begin : g_bad_out_w
        $error("rng_fetch_ctrl: OUT_W must divide 128");
    end
    if (WARMUP_CYCLES < 1 || STIR_CYCLES < 1 || REP_LIMIT < 1) begin : g_bad_counts
        $error("rng_fetch_ctrl: WARMUP_CYCLES, STIR_CYCLES and REP_LIMIT must be >= 1");
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     word_q, word_d;

`ifdef RNG_HEALTH_EN
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
    logic [127:0]     prev_q, prev_d;
    logic [REP_W-1:0] rep_q, rep_d, rep_inc;
    logic             hf_q, hf_d;
    logic             word_bad;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
`ifdef RNG_HEALTH_EN
        prev_d   = prev_q;
        rep_d    = rep_q;
        hf_d     = hf_q;
        // prev is zero after IDLE, so the zero-word test also covers the first capture
        word_bad = (rng_in == prev_q) || (rng_in == '0);
        rep_inc  = rep_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_WARMUP;
                    cnt_d   = CNT_W'(WARMUP_CYCLES - 1);
                end
            end
            S_WARMUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STIR;
                    cnt_d   = CNT_W'(STIR_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STIR: begin
                if (cnt_q == '0) begin
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LATCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                idx_d = '0;
`ifdef RNG_HEALTH_EN
                if (word_bad) begin
                    rep_d = rep_inc;
                    if (32'(rep_inc) >= REP_LIMIT) begin
                        state_d = S_FAIL;
                        hf_d    = 1'b1;
                    end else begin
                        state_d = S_STIR;
                        cnt_d   = CNT_W'(STIR_CYCLES - 1);
                    end
                end else begin
                    rep_d   = '0;
                    prev_d  = rng_in;
                    word_d  = rng_in;
                    state_d = S_SERVE;
                end
`else
                word_d  = rng_in;
                state_d = S_SERVE;
`endif
            end
            S_SERVE: begin
                if (rnd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STIR;
                        cnt_d   = CNT_W'(STIR_CYCLES - 1);
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase

        // run low overrides any transition except from FAIL; buffered data is discarded
        if (!run && state_q != S_IDLE && state_q != S_FAIL) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            word_d  = '0;
`ifdef RNG_HEALTH_EN
            prev_d  = '0;
            rep_d   = '0;
            hf_d    = hf_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
`ifdef RNG_HEALTH_EN
            prev_q  <= '0;
            rep_q   <= '0;
            hf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
`ifdef RNG_HEALTH_EN
            prev_q  <= prev_d;
            rep_q   <= rep_d;
            hf_q    <= hf_d;
`endif
        end
    end

    always_comb begin
        rnd_data = '0;
        if (state_q == S_SERVE) begin
            for (int unsigned i = 0; i < NCHUNK; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    rnd_data = word_q[i*OUT_W +: OUT_W];
                end
            end
        end
    end

    assign gen_enable = (state_q == S_WARMUP) || (state_q == S_STIR) || (state_q == S_LATCH);
    assign gen_latch  = (state_q == S_LATCH);
    assign rnd_valid  = (state_q == S_SERVE);
    assign busy       = (state_q != S_IDLE);
`ifdef RNG_HEALTH_EN
    assign health_fail = hf_q;
`else
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_rng_fetch_ctrl.sv
// Directed self-checking bench for rng_fetch_ctrl with WARMUP=8, STIR=2, OUT_W=32, REP_LIMIT=3.
module tb_rng_fetch_ctrl;
    localparam logic [127:0] WORD_A = 128'hFEDCBA98_76543210_01234567_89ABCDEF;

    logic         clk = 1'b0;
    logic         rst_n, run, rnd_ready;
    logic [127:0] rng_in;
    logic         gen_enable, gen_latch, rnd_valid, busy, health_fail;
    logic [31:0]  rnd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        run;
        logic        ready;
        logic        en;
        logic        latch;
        logic        valid;
        logic        busy;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[22];

    always #5 clk = ~clk;

    rng_fetch_ctrl #(
        .WARMUP_CYCLES(8),
        .STIR_CYCLES  (2),
        .OUT_W        (32),
        .REP_LIMIT    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .rng_in     (rng_in),
        .gen_enable (gen_enable),
        .gen_latch  (gen_latch),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .busy       (busy),
        .health_fail(health_fail)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    32'(gen_enable),  32'd0);
        check({tag, "_latch"}, 32'(gen_latch),   32'd0);
        check({tag, "_valid"}, 32'(rnd_valid),   32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_hf"},    32'(health_fail), 32'd0);
        check({tag, "_data"},  rnd_data,         32'd0);
    endtask

    // Leaves the bench at the start of an IDLE cycle with run low.
    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          en_cnt;
        int          latch_c;
        bit          seen;
        logic        exp_v;
        logic [31:0] exp_d;

        rng_in = WORD_A;

        // Test 1: nominal flow, table-driven over cycles 0..21
        for (int c = 0; c < 22; c++) begin
            tbl[c].run   = 1'b1;
            tbl[c].ready = 1'b1;
            tbl[c].en    = (c >= 1 && c <= 11) || (c >= 17 && c <= 19);
            tbl[c].latch = (c == 11) || (c == 19);
            tbl[c].valid = (c >= 13 && c <= 16) || (c == 21);
            tbl[c].busy  = (c != 0);
            case (c)
                13, 21:  tbl[c].data = 32'h89ABCDEF;
                14:      tbl[c].data = 32'h01234567;
                15:      tbl[c].data = 32'h76543210;
                16:      tbl[c].data = 32'hFEDCBA98;
                default: tbl[c].data = 32'h0;
            endcase
        end
        do_reset();
        for (int c = 0; c < 22; c++) begin
            run       = tbl[c].run;
            rnd_ready = tbl[c].ready;
            @(negedge clk);
            check($sformatf("t1_en[%0d]", c),    32'(gen_enable), 32'(tbl[c].en));
            check($sformatf("t1_latch[%0d]", c), 32'(gen_latch),  32'(tbl[c].latch));
            check($sformatf("t1_valid[%0d]", c), 32'(rnd_valid),  32'(tbl[c].valid));
            check($sformatf("t1_busy[%0d]", c),  32'(busy),       32'(tbl[c].busy));
            if (tbl[c].valid) check($sformatf("t1_data[%0d]", c), rnd_data, tbl[c].data);
            next_cycle();
        end

        // Test 2: backpressure on chunk 1 for 5 cycles
        do_reset();
        run = 1'b1;
        rnd_ready = 1'b1;
        for (int c = 0; c <= 26; c++) begin
            rnd_ready = !(c >= 14 && c <= 18);
            exp_v = (c >= 13 && c <= 21) || (c == 26);
            case (c)
                13, 26:  exp_d = 32'h89ABCDEF;
                20:      exp_d = 32'h76543210;
                21:      exp_d = 32'hFEDCBA98;
                default: exp_d = 32'h01234567;
            endcase
            @(negedge clk);
            check($sformatf("t2_valid[%0d]", c), 32'(rnd_valid), 32'(exp_v));
            if (exp_v) check($sformatf("t2_data[%0d]", c), rnd_data, exp_d);
            next_cycle();
        end

        // Test 3: run dropped while serving idx 2, then restored
        do_reset();
        run = 1'b1;
        rnd_ready = 1'b1;
        repeat (15) next_cycle();
        run = 1'b0;
        @(negedge clk);
        check("t3_idx2_data", rnd_data, 32'h76543210);
        next_cycle();
        @(negedge clk);
        check("t3_drop_valid", 32'(rnd_valid),  32'd0);
        check("t3_drop_en",    32'(gen_enable), 32'd0);
        check("t3_drop_latch", 32'(gen_latch),  32'd0);
        check("t3_drop_busy",  32'(busy),       32'd0);
        next_cycle();
        run = 1'b1;
        en_cnt  = 0;
        latch_c = -1;
        seen    = 1'b0;
        for (int c = 17; c <= 30; c++) begin
            @(negedge clk);
            if (!seen) begin
                if (gen_enable) en_cnt++;
                if (gen_latch) begin
                    seen    = 1'b1;
                    latch_c = c;
                end
            end
            if (c == 30) begin
                check("t3_restart_valid", 32'(rnd_valid), 32'd1);
                check("t3_restart_data",  rnd_data,       32'h89ABCDEF);
            end
            next_cycle();
        end
        check("t3_en_before_latch", 32'(en_cnt),  32'd11);
        check("t3_latch_cycle",     32'(latch_c), 32'd28);

        // Test 4: async reset during STIR
        do_reset();
        run = 1'b1;
        rnd_ready = 1'b1;
        repeat (9) next_cycle();
        @(negedge clk);
        check("t4_stir_en", 32'(gen_enable), 32'd1);
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t4_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            @(negedge clk);
            if (k >= 11) check($sformatf("t4_valid[%0d]", k), 32'(rnd_valid), 32'(k == 13));
        end

`ifdef RNG_HEALTH_EN
        // Test 5: constant generator output trips the repetition test
        do_reset();
        rng_in = WORD_A;
        rnd_ready = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            run = !(c >= 31 && c <= 33);
            @(negedge clk);
            check($sformatf("t5_valid[%0d]", c), 32'(rnd_valid),   32'(c >= 13 && c <= 16));
            check($sformatf("t5_hf[%0d]", c),    32'(health_fail), 32'(c >= 29));
            if (c >= 29) begin
                check($sformatf("t5_en[%0d]", c),   32'(gen_enable), 32'd0);
                check($sformatf("t5_busy[%0d]", c), 32'(busy),       32'd1);
            end
            next_cycle();
        end

        // Test 6: all-zero words are never served
        do_reset();
        rng_in = '0;
        run = 1'b1;
        rnd_ready = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            check($sformatf("t6_valid[%0d]", c), 32'(rnd_valid),   32'd0);
            check($sformatf("t6_hf[%0d]", c),    32'(health_fail), 32'(c >= 21));
            next_cycle();
        end
        do_reset();
`else
        // Test 6 (feature compiled out): the zero word is served normally
        do_reset();
        rng_in = '0;
        run = 1'b1;
        rnd_ready = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            check($sformatf("t6_valid[%0d]", c), 32'(rnd_valid),
                  32'((c >= 13 && c <= 16) || (c >= 21 && c <= 24) || (c >= 29)));
            check($sformatf("t6_hf[%0d]", c), 32'(health_fail), 32'd0);
            if (rnd_valid) check($sformatf("t6_data[%0d]", c), rnd_data, 32'd0);
            next_cycle();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
